// File: rtl/path_delay_sequencer.sv
// Launch/measure sequencer for one delay path under test, reporting the cycle count over valid/ready.
// Define DELAY_ACCUM_EN to run 2^LOG_TRIALS trials and report their sum; otherwise one trial is run.
module path_delay_sequencer #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned MAX_CYC    = 1000,
    parameter int unsigned LOG_TRIALS = 3,
    parameter bit          PATH_INV   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        launch,
    input  logic                        path_out,
    output logic [CNT_W+LOG_TRIALS-1:0] result,
    output logic                        timeout,
    output logic                        result_valid,
    input  logic                        result_ready
);

    localparam int unsigned ACC_W = CNT_W + LOG_TRIALS;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_CYC);
    localparam logic [ACC_W-1:0] ACC_MAX     = ACC_W'(MAX_CYC);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LAUNCH,
        MEASURE,
        NEXT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               timeout_q, timeout_d;
    logic               launch_q, launch_d;
    logic               sync1_q, ps_q;
    logic               exp_lvl;
    logic               last_trial;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            timeout_q <= 1'b0;
            launch_q  <= 1'b0;
            sync1_q   <= 1'b0;
            ps_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            timeout_q <= timeout_d;
            launch_q  <= launch_d;
            sync1_q   <= path_out;
            ps_q      <= sync1_q;
        end
    end

`ifdef DELAY_ACCUM_EN
    logic [LOG_TRIALS-1:0] trial_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trial_q <= '0;
        end else if (state_q == IDLE) begin
            trial_q <= '0;
        end else if (state_q == NEXT && !last_trial) begin
            trial_q <= trial_q + 1'b1;
        end
    end

    assign last_trial = &trial_q;
`else
    assign last_trial = 1'b1;
`endif

    assign exp_lvl = launch_q ^ PATH_INV;

    // launch_d is high only while the next state is MEASURE, so the registered
    // launch rises at the end of LAUNCH and drops at the end of MEASURE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        timeout_d = timeout_q;
        launch_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETTLE;
                    cnt_d     = '0;
                    acc_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (ps_q != PATH_INV) begin
                        timeout_d = 1'b1;
                        acc_d     = acc_q + ACC_MAX;
                        state_d   = NEXT;
                    end else begin
                        state_d = LAUNCH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LAUNCH: begin
                launch_d = 1'b1;
                cnt_d    = '0;
                state_d  = MEASURE;
            end
            MEASURE: begin
                if (ps_q == exp_lvl) begin
                    acc_d   = acc_q + ACC_W'(cnt_q);
                    state_d = NEXT;
                end else if (cnt_q == CNT_MAX) begin
                    acc_d     = acc_q + ACC_MAX;
                    timeout_d = 1'b1;
                    state_d   = NEXT;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    launch_d = 1'b1;
                end
            end
            NEXT: begin
                cnt_d   = '0;
                state_d = last_trial ? DONE : SETTLE;
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign launch       = launch_q;
    assign result       = acc_q;
    assign timeout      = timeout_q;
    assign result_valid = (state_q == DONE);

endmodule
